cic_comp_fir: RTL and testbench
===============================

// Module: cic_comp_fir
// PURPOSE
//  CIC droop-compensation FIR with optional decimate-by-2. Sits directly downstream of the 5-stage CIC decimator.
//  Consumes its 12-bit sample and half-duty sample clock, both already in the osc_clk domain.
//  Runs a 16-tap symmetric FIR with one serial MAC and emits a 12-bit filtered sample plus a 1-cycle valid.
//  Output feeds the demodulator.
// PARAMETERS
//  DECIM     2   output one result per DECIM accepted samples; legal values 1 or 2
//  ACC_W     34  accumulator width (12b data + 16b coef + 4b tap growth, plus margin)
// PORTS
//  osc_clk    in   1   single system clock; all logic is on its rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_data    in   12  signed sample from the CIC (its d_out)
//  in_clk     in   1   CIC sample clock (its d_clk); a rising edge marks a new in_data
//  out_data   out  12  signed filtered sample; held between updates
//  out_valid  out  1   1-cycle pulse when out_data updates
//  sat        out  1   1-cycle pulse with out_valid when the result was clipped
//  overrun    out  1   sticky: an input arrived while the MAC was busy; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_data=0, out_valid=0, sat=0, overrun=0.
//   - Delay line, accumulator and decimation counter are all zeroed; FSM goes to IDLE.
//   - Reset asserted mid-MAC discards the partial result; no out_valid is produced.
//  Input:
//   - in_clk is registered twice (q1, q2).
//   - accept = q1 & ~q2. On the accept cycle in_data is captured into the 16-entry delay line.
//   - The delay line is circular, with a write pointer; the pointer wraps 15->0.
//  Decimation counter:
//   - Counts accepted samples 0..DECIM-1.
//   - The MAC starts on the accept that wraps the counter to 0.
//   - With DECIM=1, every accept starts the MAC.
//  Coefficients (signed 16b, Q15, symmetric):
//   - h[k] = h[15-k]; h[0..7] = -64, -192, 128, 640, 256, -1600, 1024, 16192.
//   - Sum = 32768, i.e. DC gain 1.0.
//  FSM:
//   - IDLE: wait for MAC start.
//   - MAC: 16 cycles. acc += x[n-k]*h[k] for k=0..15, x[n] = newest sample.
//   - ROUND: acc + 2^14, then arithmetic >>>15.
//   - SAT: clip to [-2048, 2047].
//   - OUT: load out_data, pulse out_valid (and sat if clipped), return to IDLE.
//   - Latency: out_valid is high exactly 19 cycles after the accept cycle.
//  Busy rule:
//   - An accept in MAC/ROUND/SAT/OUT is dropped: no delay-line write, no counter step.
//   - Such an accept sets overrun.
//   - Minimum input spacing is therefore 20 osc_clk cycles.
//  Arithmetic:
//   - All signed.
//   - The 12x16 product is sign-extended to ACC_W; no intermediate overflow is possible.
//  Output:
//   - out_data holds its last value outside OUT.
//   - sat and out_valid are never high in any other cycle.
// TESTING
//  1 Impulse, DECIM=1, spacing 32: in=2047 once, then zeros.
//    -> 16 outputs: -4, -12, 8, 40, 16, -100, 64, 1012, then mirrored; then 0.
//  2 DC, DECIM=1: constant 1000.
//    -> from the 16th output on, out_data=1000 and sat=0.
//  3 Saturation: feed +2047/-2048 matched to sign(h[k]) over the window.
//    -> out_data=2047 with sat=1 on that output.
//    -> Negated pattern gives -2048 with sat=1.
//  4 DECIM=2: 10 accepts, spacing 25.
//    -> exactly 5 out_valid pulses, each 19 cycles after an even-numbered accept.
//  5 Overrun: two in_clk rising edges 6 cycles apart.
//    -> second sample ignored (impulse output unchanged vs test 1); overrun=1 until reset.
//  6 Reset: assert rst_n=0 in MAC cycle 8, release after 3 cycles.
//    -> no out_valid; all outputs 0.
//    -> Next impulse reproduces test 1 exactly.

Source files
------------

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: CIC droop-compensation FIR with optional decimate-by-2.
// A 16-tap symmetric Q15 FIR is evaluated with one serial MAC. One result is
// produced per DECIM accepted samples.
// Ports:
//   osc_clk   - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_data   - signed 12-bit sample from the CIC
//   in_clk    - CIC sample clock; a rising edge marks a new in_data
//   out_data  - signed 12-bit filtered sample, held between updates
//   out_valid - 1-cycle pulse when out_data updates
//   sat       - 1-cycle pulse alongside out_valid when the result was clipped
//   overrun   - sticky flag: a sample arrived while the MAC was busy
module cic_comp_fir #(
  parameter int unsigned DECIM = 2,
  parameter int unsigned ACC_W = 34
) (
  input  logic               osc_clk,
  input  logic               rst_n,
  input  logic signed [11:0] in_data,
  input  logic               in_clk,
  output logic signed [11:0] out_data,
  output logic               out_valid,
  output logic               sat,
  output logic               overrun
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned TAPS   = 16;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned CNT_W  = 1;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(16384);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2048);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_ROUND = 3'd2,
    S_SAT   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                    state;
  logic                      q1;
  logic                      q2;
  logic                      accept;
  logic signed [DATA_W-1:0]  dl [TAPS];
  logic [PTR_W-1:0]          wp;
  logic [PTR_W-1:0]          rd;
  logic [PTR_W-1:0]          k;
  logic [CNT_W-1:0]          dcnt;
  logic                      wrap;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [DATA_W-1:0]  clip;
  logic                      clipped;

  // Half of the symmetric Q15 coefficient set; taps 8..15 mirror taps 7..0.
  function automatic logic signed [COEF_W-1:0] coef(input logic [PTR_W-1:0] idx);
    logic [2:0] m;
    m = idx[3] ? ~idx[2:0] : idx[2:0];
    case (m)
      3'd0:    coef = -16'sd64;
      3'd1:    coef = -16'sd192;
      3'd2:    coef = 16'sd128;
      3'd3:    coef = 16'sd640;
      3'd4:    coef = 16'sd256;
      3'd5:    coef = -16'sd1600;
      3'd6:    coef = 16'sd1024;
      default: coef = 16'sd16192;
    endcase
  endfunction

  // Rising edge of the twice-registered sample clock.
  assign accept = q1 & ~q2;

  // Decimation counter wraps on the accept that launches the MAC.
  assign wrap = (dcnt == CNT_W'(DECIM - 1));

  // Tap product, sign-extended into the accumulator width.
  always_comb begin
    prod     = dl[rd] * coef(k);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    rnd_sum  = acc + RND;
  end

  // Clip the rounded result to the 12-bit signed range.
  always_comb begin
    clip    = acc[DATA_W-1:0];
    clipped = 1'b0;
    if (acc > SAT_MAX) begin
      clip    = 12'sh7FF;
      clipped = 1'b1;
    end else if (acc < SAT_MIN) begin
      clip    = 12'sh800;
      clipped = 1'b1;
    end
  end

  // Input capture, delay line, decimation and MAC sequencing.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q1        <= 1'b0;
      q2        <= 1'b0;
      wp        <= '0;
      rd        <= '0;
      k         <= '0;
      dcnt      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) dl[i] <= '0;
    end else begin
      q1 <= in_clk;
      q2 <= q1;

      if (accept) begin
        if (state == S_IDLE) begin
          dl[wp] <= in_data;
          wp     <= wp + 1'b1;
          dcnt   <= wrap ? '0 : dcnt + 1'b1;
          if (wrap) begin
            // The slot just written is the newest sample, x[n].
            rd    <= wp;
            k     <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_MAC: begin
          acc <= acc + prod_ext;
          rd  <= rd - 1'b1;
          k   <= k + 1'b1;
          if (k == 4'd15) state <= S_ROUND;
        end
        S_ROUND: begin
          acc   <= rnd_sum >>> 15;
          state <= S_SAT;
        end
        S_SAT: begin
          out_data  <= clip;
          sat       <= clipped;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          out_valid <= 1'b0;
          sat       <= 1'b0;
          state     <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed bench for cic_comp_fir. One instance runs with
// DECIM=1, a second with DECIM=2; they share clock, reset and in_data.
module tb_cic_comp_fir;

  logic               osc_clk;
  logic               rst_n;
  logic signed [11:0] in_data;
  logic               in_clk1;
  logic               in_clk2;
  logic signed [11:0] od1, od2;
  logic               ov1, ov2, sat1, sat2, ovr1, ovr2;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt1     = 0;
  int cnt2     = 0;

  int imp_exp [17] = '{-4, -12, 8, 40, 16, -100, 64, 1012,
                       1012, 64, -100, 16, 40, 8, -12, -4, 0};
  int h_half [8]   = '{-64, -192, 128, 640, 256, -1600, 1024, 16192};

  cic_comp_fir #(.DECIM(1), .ACC_W(34)) u_dut1 (
    .osc_clk  (osc_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_clk   (in_clk1),
    .out_data (od1),
    .out_valid(ov1),
    .sat      (sat1),
    .overrun  (ovr1)
  );

  cic_comp_fir #(.DECIM(2), .ACC_W(34)) u_dut2 (
    .osc_clk  (osc_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_clk   (in_clk2),
    .out_data (od2),
    .out_valid(ov2),
    .sat      (sat2),
    .overrun  (ovr2)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  // Pulse counters for each instance.
  always @(negedge osc_clk) begin
    if (ov1) cnt1 = cnt1 + 1;
    if (ov2) cnt2 = cnt2 + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Raise the selected in_clk, then run 'spacing' cycles from the accept
  // cycle, sampling the selected instance 18, 19 and 20 cycles later.
  // With dbl set, a second in_clk edge carrying 1000 follows 6 cycles later.
  task automatic send(input logic signed [11:0] v, input bit use2, input int spacing,
                      input bit dbl, output bit v18, output bit v19,
                      output logic signed [11:0] d19, output bit s19, output bit v20);
    int drop;
    drop = dbl ? 12 : 8;
    v18 = 0; v19 = 0; v20 = 0; d19 = '0; s19 = 0;
    @(negedge osc_clk);
    in_data = v;
    if (use2) in_clk2 = 1'b1; else in_clk1 = 1'b1;
    @(posedge osc_clk);
    for (int c = 1; c < spacing; c++) begin
      @(posedge osc_clk);
      #1;
      if (dbl && c == 3) in_clk1 = 1'b0;
      if (dbl && c == 6) begin in_data = 12'sd1000; in_clk1 = 1'b1; end
      if (c == drop) begin in_clk1 = 1'b0; in_clk2 = 1'b0; in_data = '0; end
      if (c == 18) v18 = use2 ? ov2 : ov1;
      if (c == 19) begin
        v19 = use2 ? ov2 : ov1;
        d19 = use2 ? od2 : od1;
        s19 = use2 ? sat2 : sat1;
      end
      if (c == 20) v20 = use2 ? ov2 : ov1;
    end
  endtask

  initial begin
    bit v18, v19, v20, s19;
    logic signed [11:0] d19;
    logic signed [11:0] pat [16];
    int m;

    rst_n = 1'b0; in_data = '0; in_clk1 = 1'b0; in_clk2 = 1'b0;
    repeat (3) @(posedge osc_clk);
    #1;
    check("rst_out_data", od1, 0);
    check("rst_out_valid", ov1, 0);
    check("rst_sat", sat1, 0);
    check("rst_overrun", ovr1, 0);
    @(negedge osc_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge osc_clk);

    // Test 1: impulse response, DECIM=1.
    cnt1 = 0;
    for (int i = 0; i < 17; i++) begin
      send(i == 0 ? 12'sd2047 : 12'sd0, 1'b0, 32, 1'b0, v18, v19, d19, s19, v20);
      if (i == 0) begin
        check("imp_lat_pre", v18, 0);
        check("imp_lat_post", v20, 0);
      end
      check($sformatf("imp_valid[%0d]", i), v19, 1);
      check($sformatf("imp_data[%0d]", i), d19, imp_exp[i]);
    end
    check("imp_pulse_count", cnt1, 17);

    // Test 2: DC gain of one.
    for (int i = 0; i < 18; i++) begin
      send(12'sd1000, 1'b0, 21, 1'b0, v18, v19, d19, s19, v20);
      if (i >= 15) begin
        check($sformatf("dc_data[%0d]", i), d19, 1000);
        check($sformatf("dc_sat[%0d]", i), s19, 0);
      end
    end

    // Test 3: sign-matched full-scale window, then its negation.
    for (int j = 0; j < 16; j++) begin
      m = (j < 8) ? j : 15 - j;
      pat[j] = (h_half[m] < 0) ? -12'sd2048 : 12'sd2047;
    end
    for (int j = 0; j < 16; j++) send(pat[j], 1'b0, 21, 1'b0, v18, v19, d19, s19, v20);
    check("satp_valid", v19, 1);
    check("satp_data", d19, 2047);
    check("satp_sat", s19, 1);
    for (int j = 0; j < 16; j++) begin
      m = (j < 8) ? j : 15 - j;
      pat[j] = (h_half[m] < 0) ? 12'sd2047 : -12'sd2048;
    end
    for (int j = 0; j < 16; j++) send(pat[j], 1'b0, 21, 1'b0, v18, v19, d19, s19, v20);
    check("satn_data", d19, -2048);
    check("satn_sat", s19, 1);
    check("no_overrun_yet", ovr1, 0);

    // Test 4: DECIM=2, output only after every second accept.
    cnt2 = 0;
    for (int i = 1; i <= 10; i++) begin
      send(12'sd500, 1'b1, 25, 1'b0, v18, v19, d19, s19, v20);
      check($sformatf("dec2_valid[%0d]", i), v19, (i % 2 == 0) ? 1 : 0);
    end
    repeat (25) @(posedge osc_clk);
    #1;
    check("dec2_pulse_count", cnt2, 5);

    // Test 5: second edge 6 cycles after the first is dropped.
    for (int i = 0; i < 16; i++) send(12'sd0, 1'b0, 21, 1'b0, v18, v19, d19, s19, v20);
    check("ovr_before", ovr1, 0);
    for (int i = 0; i < 16; i++) begin
      send(i == 0 ? 12'sd2047 : 12'sd0, 1'b0, 32, i == 0, v18, v19, d19, s19, v20);
      check($sformatf("ovr_imp_data[%0d]", i), d19, imp_exp[i]);
    end
    check("ovr_sticky", ovr1, 1);
    check("held_out_data", od1, -4);

    // Test 6: reset during the MAC discards the result.
    @(negedge osc_clk);
    in_data = 12'sd2047;
    in_clk1 = 1'b1;
    @(posedge osc_clk);
    repeat (8) @(posedge osc_clk);
    #1;
    rst_n = 1'b0;
    in_clk1 = 1'b0;
    in_data = '0;
    #1;
    check("mid_rst_out_data", od1, 0);
    check("mid_rst_out_valid", ov1, 0);
    check("mid_rst_overrun", ovr1, 0);
    repeat (3) @(posedge osc_clk);
    @(negedge osc_clk);
    rst_n = 1'b1;
    cnt1 = 0;
    repeat (30) @(posedge osc_clk);
    #1;
    check("mid_rst_no_valid", cnt1, 0);
    check("mid_rst_data_after", od1, 0);
    for (int i = 0; i < 17; i++) begin
      send(i == 0 ? 12'sd2047 : 12'sd0, 1'b0, 32, 1'b0, v18, v19, d19, s19, v20);
      check($sformatf("rst_imp_data[%0d]", i), d19, imp_exp[i]);
    end
    check("rst_imp_overrun", ovr1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
